// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants and FSM state type shared by the sequential ALU
package alu_pkg;

    localparam logic [7:0] OP_ADD = 8'h2B;
    localparam logic [7:0] OP_SUB = 8'h2D;
    localparam logic [7:0] OP_MUL = 8'h2A;
    localparam logic [7:0] OP_DIV = 8'h2F;
    localparam logic [7:0] OP_AND = 8'h26;
    localparam logic [7:0] OP_OR  = 8'h7C;

    typedef enum logic {
        IDLE = 1'b0,
        DIV  = 1'b1
    } state_t;

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring divider, one quotient bit per clock, MSB first
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             busy;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] div_q;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    // The quotient register doubles as the dividend shifter: its MSB feeds the
    // partial remainder while new quotient bits enter at the LSB.
    always_comb begin
        trial    = {rem_q, quo_q[WIDTH-1]};
        diff     = trial - {1'b0, div_q};
        fits     = (trial >= {1'b0, div_q});
        rem_next = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_next = {quo_q[WIDTH-2:0], fits};
    end

    // Outputs are the values produced by the current iteration, so the final
    // result is available in the same cycle that done is raised.
    assign done      = busy && (count == LAST);
    assign quotient  = quo_next;
    assign remainder = rem_next;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy  <= 1'b0;
            count <= '0;
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            count <= '0;
            rem_q <= '0;
            quo_q <= dividend;
            div_q <= divisor;
        end else if (busy) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            count <= count + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - WIDTH-bit ALU with handshake, registered results and iterative divide
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic [7:0]       operation,
    output logic             out_valid,
    output logic [WIDTH-1:0] result_data,
    output logic [WIDTH-1:0] result_hi,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             zero
);

    state_t state_q;
    state_t state_d;

    logic accept;
    logic div_start;
    logic single_done;
    logic div_done;

    logic [WIDTH-1:0]   div_quotient;
    logic [WIDTH-1:0]   div_remainder;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   alu_lo;
    logic [WIDTH-1:0]   alu_hi;
    logic               alu_ovf;
    logic               alu_dbz;

    assign accept      = in_valid && in_ready;
    assign div_start   = accept && (operation == OP_DIV) && (data_b != '0);
    assign single_done = accept && !div_start;

    seq_divider #(.WIDTH(WIDTH)) u_divider (
        .clock     (clock),
        .reset     (reset),
        .start     (div_start),
        .dividend  (data_a),
        .divisor   (data_b),
        .done      (div_done),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (div_start) state_d = DIV;
            DIV:     if (div_done)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == IDLE);
    end

    // Single-cycle datapath, including the divide-by-zero shortcut.
    always_comb begin
        sum     = {1'b0, data_a} + {1'b0, data_b};
        prod    = {{WIDTH{1'b0}}, data_a} * {{WIDTH{1'b0}}, data_b};
        alu_lo  = '0;
        alu_hi  = '0;
        alu_ovf = 1'b0;
        alu_dbz = 1'b0;
        case (operation)
            OP_ADD: begin
                alu_lo  = sum[WIDTH-1:0];
                alu_hi  = {{(WIDTH-1){1'b0}}, sum[WIDTH]};
                alu_ovf = sum[WIDTH];
            end
            OP_SUB: begin
                alu_lo  = data_a - data_b;
                alu_ovf = (data_a < data_b);
            end
            OP_MUL: begin
                alu_lo  = prod[WIDTH-1:0];
                alu_hi  = prod[2*WIDTH-1:WIDTH];
                alu_ovf = (prod[2*WIDTH-1:WIDTH] != '0);
            end
            OP_DIV: begin
                alu_lo  = '1;
                alu_hi  = data_a;
                alu_dbz = 1'b1;
            end
            OP_AND:  alu_lo = data_a & data_b;
            OP_OR:   alu_lo = data_a | data_b;
            default: alu_lo = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            result_data <= '0;
            result_hi   <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            zero        <= 1'b0;
        end else begin
            out_valid <= single_done || div_done;
            if (single_done) begin
                result_data <= alu_lo;
                result_hi   <= alu_hi;
                overflow    <= alu_ovf;
                div_by_zero <= alu_dbz;
                zero        <= ({alu_hi, alu_lo} == '0);
            end else if (div_done) begin
                result_data <= div_quotient;
                result_hi   <= div_remainder;
                overflow    <= 1'b0;
                div_by_zero <= 1'b0;
                zero        <= ({div_remainder, div_quotient} == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb/tb_alu_seq_unit.sv - scoreboard bench for alu_seq_unit at WIDTH=8 and WIDTH=16
module tb_alu_seq_unit;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic        v8 = 1'b0, r8, o8_valid, o8_ovf, o8_dbz, o8_zero;
    logic [7:0]  a8 = '0, b8 = '0, o8_lo, o8_hi;
    logic        v16 = 1'b0, r16, o16_valid, o16_ovf, o16_dbz, o16_zero;
    logic [15:0] a16 = '0, b16 = '0, o16_lo, o16_hi;
    logic [7:0]  op = '0;

    alu_seq_unit #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .in_valid(v8), .in_ready(r8),
        .data_a(a8), .data_b(b8), .operation(op), .out_valid(o8_valid),
        .result_data(o8_lo), .result_hi(o8_hi), .overflow(o8_ovf),
        .div_by_zero(o8_dbz), .zero(o8_zero)
    );

    alu_seq_unit #(.WIDTH(16)) dut16 (
        .clock(clock), .reset(reset), .in_valid(v16), .in_ready(r16),
        .data_a(a16), .data_b(b16), .operation(op), .out_valid(o16_valid),
        .result_data(o16_lo), .result_hi(o16_hi), .overflow(o16_ovf),
        .div_by_zero(o16_dbz), .zero(o16_zero)
    );

    typedef struct {
        string       name;
        logic [15:0] lo;
        logic [15:0] hi;
        logic        ovf;
        logic        dbz;
        logic        zero;
        int          due;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    exp_t m8, m16;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic score(input exp_t e, input logic [15:0] lo, input logic [15:0] hi,
                         input logic ovf, input logic dbz, input logic z);
        check({e.name, " result_data"}, lo, e.lo);
        check({e.name, " result_hi"}, hi, e.hi);
        check({e.name, " overflow"}, ovf, e.ovf);
        check({e.name, " div_by_zero"}, dbz, e.dbz);
        check({e.name, " zero"}, z, e.zero);
        check({e.name, " out_valid cycle"}, cyc, e.due);
    endtask

    always @(negedge clock) begin
        if (reset && o8_valid) begin
            if (q8.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL unexpected out_valid (w8): got 1, expected 0");
            end else begin
                m8 = q8.pop_front();
                score(m8, o8_lo, o8_hi, o8_ovf, o8_dbz, o8_zero);
            end
        end
        if (reset && o16_valid) begin
            if (q16.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL unexpected out_valid (w16): got 1, expected 0");
            end else begin
                m16 = q16.pop_front();
                score(m16, o16_lo, o16_hi, o16_ovf, o16_dbz, o16_zero);
            end
        end
    end

    task automatic issue(input bit wide, input string name, input logic [15:0] a,
                         input logic [15:0] b, input logic [7:0] opc,
                         input logic [15:0] lo, input logic [15:0] hi,
                         input logic ovf, input logic dbz, input logic z);
        int   guard = 0;
        exp_t e;
        @(negedge clock);
        while (!(wide ? r16 : r8) && guard < 40) begin
            v8 = 1'b0; v16 = 1'b0;
            guard++;
            @(negedge clock);
        end
        if (guard >= 40) begin
            vectors++; miscompares++;
            $display("FAIL %s in_ready timeout: got 0, expected 1", name);
        end
        v8 = !wide; v16 = wide;
        a8 = a[7:0]; b8 = b[7:0]; a16 = a; b16 = b; op = opc;
        e.name = name; e.lo = lo; e.hi = hi; e.ovf = ovf; e.dbz = dbz; e.zero = z;
        e.due = cyc + 1 + (((opc == 8'h2F) && (b != 16'h0)) ? (wide ? 16 : 8) : 0);
        if (wide) q16.push_back(e); else q8.push_back(e);
        @(posedge clock);
    endtask

    // Counts the cycles in_ready stays low after a divide; optionally pokes
    // in_valid with an add throughout, which must be ignored.
    task automatic div_wait(input bit wide, input bit inject, input string name);
        int n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (wide ? r16 : r8) break;
            n++;
            if (inject) begin
                v8 = !wide; v16 = wide; op = 8'h2B;
                a8 = 8'd1; b8 = 8'd1; a16 = 16'd1; b16 = 16'd1;
            end
        end
        v8 = 1'b0; v16 = 1'b0;
        check({name, " in_ready low cycles"}, n, wide ? 16 : 8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("reset in_ready w8", r8, 1);
        check("reset in_ready w16", r16, 1);
        check("reset outputs w8", {o8_valid, o8_lo, o8_hi, o8_ovf, o8_dbz, o8_zero}, 0);
        check("reset outputs w16", {o16_valid, o16_lo, o16_hi, o16_ovf, o16_dbz, o16_zero}, 0);
        @(negedge clock);
        reset = 1'b1;

        issue(0, "add 200+100", 200, 100, 8'h2B, 16'h2C, 16'h01, 1, 0, 0);
        issue(0, "add 1+1",       1,   1, 8'h2B, 16'h02, 16'h00, 0, 0, 0);
        issue(0, "sub 5-7",       5,   7, 8'h2D, 16'hFE, 16'h00, 1, 0, 0);
        issue(0, "mul 20*20",    20,  20, 8'h2A, 16'h90, 16'h01, 1, 0, 0);
        issue(0, "and f0&3c", 16'hF0, 16'h3C, 8'h26, 16'h30, 16'h00, 0, 0, 0);
        issue(0, "or f0|0f",  16'hF0, 16'h0F, 8'h7C, 16'hFF, 16'h00, 0, 0, 0);
        issue(0, "sub 7-7",       7,   7, 8'h2D, 16'h00, 16'h00, 0, 0, 1);
        issue(0, "add ff+01", 16'hFF, 16'h01, 8'h2B, 16'h00, 16'h01, 1, 0, 0);
        issue(0, "div 200/7",   200,   7, 8'h2F, 16'd28, 16'd4, 0, 0, 0);
        div_wait(0, 1, "div 200/7");
        issue(0, "div 9/0",       9,   0, 8'h2F, 16'hFF, 16'h09, 0, 1, 0);
        issue(0, "add 3+4",       3,   4, 8'h2B, 16'h07, 16'h00, 0, 0, 0);
        issue(0, "opcode 41",    12,  34, 8'h41, 16'h00, 16'h00, 0, 0, 1);
        issue(0, "div 255/1",   255,   1, 8'h2F, 16'hFF, 16'h00, 0, 0, 0);
        div_wait(0, 0, "div 255/1");
        issue(0, "div 5/200",     5, 200, 8'h2F, 16'h00, 16'h05, 0, 0, 0);
        div_wait(0, 0, "div 5/200");

        issue(0, "aborted div", 200, 7, 8'h2F, 16'd28, 16'd4, 0, 0, 0);
        repeat (4) @(posedge clock);
        #2;
        reset = 1'b0;
        v8 = 1'b0;
        q8.delete();
        #1;
        check("abort in_ready", r8, 1);
        check("abort outputs", {o8_valid, o8_lo, o8_hi, o8_ovf, o8_dbz, o8_zero}, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        repeat (12) @(negedge clock);
        issue(0, "add 1+1 after reset", 1, 1, 8'h2B, 16'h02, 16'h00, 0, 0, 0);

        issue(1, "w16 mul ffff*ffff", 16'hFFFF, 16'hFFFF, 8'h2A, 16'h0001, 16'hFFFE, 1, 0, 0);
        issue(1, "w16 add ffff+1",    16'hFFFF, 16'h0001, 8'h2B, 16'h0000, 16'h0001, 1, 0, 0);
        issue(1, "w16 sub 1000-1",    16'h1000, 16'h0001, 8'h2D, 16'h0FFF, 16'h0000, 0, 0, 0);
        issue(1, "w16 div 50000/300", 16'd50000, 16'd300, 8'h2F, 16'd166, 16'd200, 0, 0, 0);
        div_wait(1, 1, "w16 div 50000/300");
        issue(1, "w16 div ffff/ff",   16'hFFFF, 16'h00FF, 8'h2F, 16'h0101, 16'h0000, 0, 0, 0);
        div_wait(1, 0, "w16 div ffff/ff");
        issue(1, "w16 div 1234/0",    16'h1234, 16'h0000, 8'h2F, 16'hFFFF, 16'h1234, 0, 1, 0);

        @(negedge clock);
        v8 = 1'b0; v16 = 1'b0;
        repeat (20) @(negedge clock);
        check("pending results w8", q8.size(), 0);
        check("pending results w16", q16.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
